// File: rtl/truth_table_checker_pkg.sv
// Shared definitions for the truth-table checker: FSM states and sweep geometry.
package truth_table_checker_pkg;

  localparam int NVEC  = 16;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/truth_table_checker_dwell_timer.sv
// Dwell counter: counts cycles a vector has been held; last flags count == HOLD-1.
module dwell_timer #(
  parameter int HOLD = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [7:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign last = (count == 8'(HOLD - 1));

endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive 4-input stimulus sweeper that records the DUT truth table and
// scores it against an expected minterm map.
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int          HOLD     = 10,
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        f,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] minterms,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err,
  output logic        err_valid
);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             last;
  logic             mismatch;
  logic [4:0]       err_next;

  // The timer idles at zero outside DRIVE, so the first dwell starts clean.
  dwell_timer #(.HOLD(HOLD)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   ((state != ST_DRIVE) || last),
    .en    (state == ST_DRIVE),
    .last  (last)
  );

  assign mismatch = (f != EXPECTED[idx]);
  assign err_next = err_count + {4'b0, mismatch};
  assign {a, b, c, d} = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      minterms  <= '0;
      err_count <= '0;
      first_err <= '0;
      err_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= ST_DRIVE;
            busy      <= 1'b1;
            idx       <= '0;
            pass      <= 1'b0;
            minterms  <= '0;
            err_count <= '0;
            first_err <= '0;
            err_valid <= 1'b0;
          end
        end

        ST_DRIVE: begin
          if (last) begin
            minterms[idx] <= f;
            err_count     <= err_next;
            if (mismatch && !err_valid) begin
              first_err <= idx;
              err_valid <= 1'b1;
            end
            // Results are final on the same edge that raises done.
            if (idx == IDX_W'(NVEC - 1)) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              idx   <= '0;
              pass  <= (err_next == 5'd0);
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench for truth_table_checker: three instances cover HOLD=10
// against XOR4, HOLD=1 against all-ones, and a glitching response.
module tb_truth_table_checker;

  typedef struct {
    logic [15:0] mt;
    logic [4:0]  ec;
    logic [3:0]  fe;
    logic        ev;
    logic        ps;
    int          done_edge;
  } exp_t;

  typedef struct {
    logic        busy;
    logic        done;
    logic        pass;
    logic        ev;
    logic [3:0]  vec;
    logic [15:0] mt;
    logic [4:0]  ec;
    logic [3:0]  fe;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic f0, f1, f2;
  int   mode0 = 0;

  logic        a0, b0, c0, d0, busy0, done0, pass0, ev0;
  logic        a1, b1, c1, d1, busy1, done1, pass1, ev1;
  logic        a2, b2, c2, d2, busy2, done2, pass2, ev2;
  logic [15:0] mt0, mt1, mt2;
  logic [4:0]  ec0, ec1, ec2;
  logic [3:0]  fe0, fe1, fe2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int dcnt0 = 0;
  int g_cnt;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (done0) dcnt0++;

  // Glitch source for instance 2: high for the first HOLD-1 cycles of each dwell.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     g_cnt <= 0;
    else if (busy2) g_cnt <= (g_cnt == 9) ? 0 : g_cnt + 1;
    else            g_cnt <= 0;
  end

  assign f0 = (mode0 != 0) ? 1'b0 : (a0 ^ b0 ^ c0 ^ d0);
  assign f1 = 1'b1;
  assign f2 = busy2 && (g_cnt != 9);

  truth_table_checker #(.HOLD(10), .EXPECTED(16'h6996)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .f(f0),
    .a(a0), .b(b0), .c(c0), .d(d0), .busy(busy0), .done(done0), .pass(pass0),
    .minterms(mt0), .err_count(ec0), .first_err(fe0), .err_valid(ev0)
  );

  truth_table_checker #(.HOLD(1), .EXPECTED(16'hFFFF)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .f(f1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .pass(pass1),
    .minterms(mt1), .err_count(ec1), .first_err(fe1), .err_valid(ev1)
  );

  truth_table_checker #(.HOLD(10), .EXPECTED(16'h0000)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .f(f2),
    .a(a2), .b(b2), .c(c2), .d(d2), .busy(busy2), .done(done2), .pass(pass2),
    .minterms(mt2), .err_count(ec2), .first_err(fe2), .err_valid(ev2)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int hold_of(input int inst);
    return (inst == 1) ? 1 : 10;
  endfunction

  function automatic logic [15:0] exp_of(input int inst);
    case (inst)
      0:       return 16'h6996;
      1:       return 16'hFFFF;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic obs_t get_obs(input int inst);
    obs_t o;
    case (inst)
      0: o = '{busy0, done0, pass0, ev0, {a0, b0, c0, d0}, mt0, ec0, fe0};
      1: o = '{busy1, done1, pass1, ev1, {a1, b1, c1, d1}, mt1, ec1, fe1};
      default: o = '{busy2, done2, pass2, ev2, {a2, b2, c2, d2}, mt2, ec2, fe2};
    endcase
    return o;
  endfunction

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0: start0 = v;
      1: start1 = v;
      default: start2 = v;
    endcase
  endtask

  // Reference model: value of f at each sampling edge, scored against EXPECTED.
  function automatic exp_t model(input int inst);
    exp_t        e;
    logic [15:0] ex;
    logic [3:0]  v;
    logic        fs;
    ex = exp_of(inst);
    e = '{16'h0, 5'd0, 4'd0, 1'b0, 1'b0, 0};
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      case (inst)
        0:       fs = (mode0 != 0) ? 1'b0 : ^v;
        1:       fs = 1'b1;
        default: fs = 1'b0;
      endcase
      e.mt[i] = fs;
      if (fs != ex[i]) begin
        e.ec = e.ec + 5'd1;
        if (!e.ev) begin
          e.fe = v;
          e.ev = 1'b1;
        end
      end
    end
    e.ps = (e.ec == 5'd0);
    return e;
  endfunction

  task automatic run_sweep(input int inst, input bit repulse);
    obs_t o;
    exp_t e;
    int   k;
    bit   got, pulsed, pulse_on;
    got = 0; pulsed = 0; pulse_on = 0;
    @(negedge clk);
    set_start(inst, 1'b1);
    @(negedge clk);
    k = cyc;
    set_start(inst, 1'b0);
    o = get_obs(inst);
    check("start_busy", o.busy, 1);
    check("start_vec0", o.vec, 0);
    check("clr_minterms", o.mt, 0);
    check("clr_err_count", o.ec, 0);
    check("clr_err_valid", o.ev, 0);
    check("clr_pass", o.pass, 0);
    e = model(inst);
    e.done_edge = k + 16 * hold_of(inst);
    sb.push_back(e);
    for (int n = 0; n < 16 * hold_of(inst) + 20 && !got; n++) begin
      @(negedge clk);
      if (pulse_on) begin
        set_start(inst, 1'b0);
        pulse_on = 0;
      end
      o = get_obs(inst);
      if (o.done) begin
        got = 1;
      end else begin
        if (inst == 1) check("step_vec", o.vec, 32'(cyc - k));
        if (repulse && !pulsed && o.vec == 4'd5) begin
          set_start(inst, 1'b1);
          pulse_on = 1;
          pulsed = 1;
        end
      end
    end
    if (!got) begin
      check("done_timeout", 0, 1);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      check("done_edge", cyc, e.done_edge);
      check("minterms", o.mt, e.mt);
      check("err_count", o.ec, e.ec);
      check("first_err", o.fe, e.fe);
      check("err_valid", o.ev, e.ev);
      check("pass", o.pass, e.ps);
      check("done_busy", o.busy, 0);
      check("done_vec", o.vec, 0);
      @(negedge clk);
      o = get_obs(inst);
      check("done_one_cycle", o.done, 0);
      check("idle_busy", o.busy, 0);
      check("held_minterms", o.mt, e.mt);
    end
  endtask

  task automatic check_zero(input string tag, input int inst);
    obs_t o;
    o = get_obs(inst);
    check({tag, "_busy"}, o.busy, 0);
    check({tag, "_done"}, o.done, 0);
    check({tag, "_pass"}, o.pass, 0);
    check({tag, "_err_valid"}, o.ev, 0);
    check({tag, "_vec"}, o.vec, 0);
    check({tag, "_minterms"}, o.mt, 0);
    check({tag, "_err_count"}, o.ec, 0);
    check({tag, "_first_err"}, o.fe, 0);
  endtask

  initial begin
    int   d;
    bit   hit;
    obs_t o;
    exp_t e;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_zero("reset", i);
    rst_n = 1'b1;

    mode0 = 0;
    run_sweep(0, 0);        // XOR4 against 6996: clean pass
    mode0 = 1;
    run_sweep(0, 0);        // f stuck low: 8 errors, first at 1
    run_sweep(1, 0);        // HOLD=1 all-ones

    mode0 = 0;
    d = dcnt0;
    run_sweep(0, 1);        // start re-pulsed mid-sweep
    repeat (5) @(negedge clk);
    check("one_done_on_repulse", 32'(dcnt0 - d), 1);

    // Asynchronous reset at vector 9 aborts the sweep with no done.
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    e = model(0);
    sb.push_back(e);
    hit = 0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(negedge clk);
      o = get_obs(0);
      if (o.vec == 4'd9) hit = 1;
    end
    check("reach_vec9", 32'(hit), 1);
    d = dcnt0;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst", 0);
    void'(sb.pop_back());
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("no_done_after_rst", 32'(dcnt0 - d), 0);
    run_sweep(0, 0);

    run_sweep(2, 0);        // early-dwell glitches must be ignored

    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Self-checking response collector for 4-input combinational exercises. It sweeps all 16 input combinations onto a DUT's `a`, `b`, `c`, `d` pins in ascending order and holds each one for a programmable dwell. At the end of each dwell it samples the DUT output `f` and builds the observed truth table as a 16-bit minterm map. It then compares that map against an expected map and reports pass/fail, an error count and the first failing index. It sits beside the DUT in the lab harness, on the receiving end of the exhaustive-vector scheme the team uses for combinational blocks.

## Interface
Parameters:
- `HOLD`, default 10: dwell per vector in clock cycles; legal range 1..255.
- `EXPECTED`, default 16'h0000: expected truth table; bit i is the value of `f` for vector i = {a,b,c,d}.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level sampled on `clk`; honored only in IDLE.
- `f`  in  1  DUT response.
- `a`, `b`, `c`, `d`  out  1 each  registered DUT stimulus; `a` is the MSB of the vector index, `d` the LSB.
- `busy`  out  1  high while sweeping.
- `done`  out  1  one-cycle pulse at the end of a sweep.
- `pass`  out  1  1 when `minterms == EXPECTED`; valid from `done` until the next `start`.
- `minterms`  out  16  observed truth table.
- `err_count`  out  5  number of mismatching vectors, 0..16.
- `first_err`  out  4  lowest mismatching index.
- `err_valid`  out  1  at least one mismatch recorded.

## Operation
- States:
  - IDLE: `busy`=0; results held.
  - DRIVE: vector `idx` on {a,b,c,d}; `dwell` counts 0..HOLD-1.
  - DONE: lasts exactly one cycle; returns to IDLE.
- IDLE→DRIVE on `start`=1. Same edge: `idx`←0, `dwell`←0, and `minterms`, `err_count`, `first_err`, `err_valid`, `pass` all cleared.
- DRIVE, `dwell`==HOLD-1:
  - `minterms[idx]`←`f`.
  - On mismatch with `EXPECTED[idx]`: `err_count`++. If `err_valid`=0, then `first_err`←`idx` and `err_valid`←1.
  - If `idx`==15 go to DONE; else `idx`++ and `dwell`←0.
- DONE: `pass`←(final `err_count`==0); {a,b,c,d}←0.
- `start` in DRIVE or DONE is ignored; no restart and no queuing.
- `f` is sampled only at dwell end. Glitches earlier in the dwell are irrelevant.
- `err_count` saturates naturally at 16, since at most 16 compares occur per sweep.

## Timing
- Reset (async, `rst_n`=0): state IDLE. `a`=`b`=`c`=`d`=0; `busy`, `done`, `pass`, `err_valid`=0; `minterms`=0; `err_count`=0; `first_err`=0.
- Reset mid-sweep aborts immediately with the values above. No `done` is produced.
- `start` sampled at edge k:
  - Vector 0 and `busy`=1 are visible after edge k.
  - Vector i is held from edge k+i·HOLD to edge k+(i+1)·HOLD and sampled at that second edge.
- After edge k+16·HOLD: `done`=1, `busy`=0, and `pass` and all result outputs are final. After edge k+16·HOLD+1: `done`=0.
- Sweep latency is 16·HOLD+1 cycles from `start` to `done`.
- `HOLD`=1: a new vector every cycle, no idle cycles between vectors.
- Back-to-back sweeps: `start` held high gives a new sweep beginning at edge k+16·HOLD+2, the first IDLE cycle.

## Structure
- Shared Verilog include `dsco_defs.vh` holds:
  - state encodings `ST_IDLE`, `ST_DRIVE`, `ST_DONE` (2 bits);
  - `NVEC`=16 and `IDX_W`=4.
- One sub-module, `dwell_timer`, is natural:
  - 8-bit counter with `clr`/`en` inputs and a `last` output (count==HOLD-1);
  - same `clk`/`rst_n`.
- The FSM, index register and result registers stay in the top module.

## Test plan
- XOR4 DUT (`f`=a^b^c^d), `EXPECTED`=16'h6996, `HOLD`=10 → `minterms`=16'h6996, `err_count`=0, `err_valid`=0, `pass`=1, `done` 161 cycles after `start`.
- `f` tied 0, `EXPECTED`=16'h6996, `HOLD`=10 → `minterms`=16'h0000, `err_count`=8, `first_err`=1, `err_valid`=1, `pass`=0.
- `HOLD`=1, `f` tied 1, `EXPECTED`=16'hFFFF → {a,b,c,d} steps 0..15 on consecutive cycles, `pass`=1, `done` 17 cycles after `start`.
- `start` re-pulsed at vector 5, `HOLD`=10 → sweep continues unaffected, exactly one `done`. Second `start` after `done` → results clear and the sweep restarts at vector 0.
- `rst_n` low at vector 9 → all outputs 0 asynchronously, before the next edge, and no `done`. A fresh `start` after release completes normally.
- `f` glitching high only during the first HOLD-1 cycles of each dwell, `EXPECTED`=16'h0000 → `minterms`=16'h0000, `pass`=1.
